edge_rate_meter: RTL and testbench

//  Downstream consumer of the 1-bit count stream from the pulse counter.

---
 rtl/edge_rate_meter.sv | 120 ++++++++++++
 tb/tb_edge_rate_meter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_rate_meter.sv
// Counts rising edges of count_in over a programmable window of clock cycles and
// holds the (saturating) total on a valid/ready result port until it is taken.
module edge_rate_meter #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             count_in,
    input  logic             start,
    input  logic [WIN_W-1:0] window,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    // Handshake: result is stable whenever result_valid is high; the result is
    // taken on any rising clk edge where result_valid and result_ready are both high.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q;
    logic               prev_q;
    logic [CNT_W-1:0]   acc_q;
    logic [CNT_W-1:0]   result_q;
    logic [WIN_W-1:0]   timer_q;
    logic               overflow_q;
    logic               busy_q;
    logic               valid_q;

    logic               edge_w;
    logic               acc_max;
    logic [CNT_W-1:0]   acc_d;

    assign edge_w  = count_in & ~prev_q;
    assign acc_max = &acc_q;
    assign acc_d   = (edge_w && !acc_max) ? acc_q + CNT_W'(1) : acc_q;

    // The edge detector keeps running in every state so the first RUN cycle
    // compares against the true previous level of count_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= count_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            timer_q    <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else if (clear) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            timer_q    <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        timer_q    <= (window == '0) ? WIN_W'(1) : window;
                        acc_q      <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    timer_q <= timer_q - WIN_W'(1);
                    if (edge_w && acc_max) begin
                        overflow_q <= 1'b1;
                    end
                    // Last sampled cycle: its edge is folded into the result.
                    if (timer_q == WIN_W'(1)) begin
                        result_q <= acc_d;
                        state_q  <= HOLD;
                        valid_q  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (result_ready) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign overflow     = overflow_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_edge_rate_meter.sv
// Bench for edge_rate_meter: two instances (8-bit and 3-bit accumulators) checked
// every cycle against a window-history model, plus directed literal checks.
module tb_edge_rate_meter;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       count_in;
  logic       start;
  logic [7:0] window;
  logic       result_ready;

  logic       busy0, valid0, ovf0;
  logic [7:0] result0;
  logic [1:0] dbg0;
  logic       busy1, valid1, ovf1;
  logic [2:0] result1;
  logic [1:0] dbg1;

  int n_cmp;
  int n_fail;

  edge_rate_meter #(.CNT_W(8), .WIN_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .count_in(count_in), .start(start),
    .window(window), .busy(busy0), .result(result0), .result_valid(valid0),
    .result_ready(result_ready), .overflow(ovf0), .dbg_state(dbg0)
  );

  edge_rate_meter #(.CNT_W(3), .WIN_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .count_in(count_in), .start(start),
    .window(window), .busy(busy1), .result(result1), .result_valid(valid1),
    .result_ready(result_ready), .overflow(ovf1), .dbg_state(dbg1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: remembers the count_in samples of the current window and derives
  // the edge total from them; one entry per DUT for the saturation limit
  int   m_st;          // 0 idle, 1 run, 2 hold
  int   m_weff;
  int   m_res [2];
  logic m_ovf [2];
  logic m_last;
  logic m_run_prev;
  logic run_q[$];
  int   m_max [2];

  function automatic int count_edges();
    int   n;
    logic p;
    n = 0;
    p = m_run_prev;
    foreach (run_q[i]) begin
      if (run_q[i] && !p) n++;
      p = run_q[i];
    end
    return n;
  endfunction

  // compare process: check at negedge, then advance the model with the inputs
  // the next rising edge will sample
  initial begin
    int e;
    m_max[0] = 255;
    m_max[1] = 7;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_st = 0; m_last = 1'b0; run_q.delete();
        for (int d = 0; d < 2; d++) begin m_res[d] = 0; m_ovf[d] = 1'b0; end
      end
      check("busy0",   32'(busy0),   32'(m_st != 0));
      check("valid0",  32'(valid0),  32'(m_st == 2));
      check("result0", 32'(result0), 32'(m_res[0]));
      check("ovf0",    32'(ovf0),    32'(m_ovf[0]));
      check("busy1",   32'(busy1),   32'(m_st != 0));
      check("valid1",  32'(valid1),  32'(m_st == 2));
      check("result1", 32'(result1), 32'(m_res[1]));
      check("ovf1",    32'(ovf1),    32'(m_ovf[1]));
      if (rst_n) begin
        if (clear) begin
          m_st = 0;
          for (int d = 0; d < 2; d++) begin m_res[d] = 0; m_ovf[d] = 1'b0; end
        end else if (m_st == 0) begin
          if (start) begin
            m_st = 1;
            m_weff = (window == 8'd0) ? 1 : int'(window);
            run_q.delete();
            m_run_prev = m_last;
            for (int d = 0; d < 2; d++) m_ovf[d] = 1'b0;
          end
        end else if (m_st == 1) begin
          run_q.push_back(count_in);
          e = count_edges();
          for (int d = 0; d < 2; d++) m_ovf[d] = (e > m_max[d]);
          if (run_q.size() == m_weff) begin
            m_st = 2;
            for (int d = 0; d < 2; d++) m_res[d] = (e > m_max[d]) ? m_max[d] : e;
          end
        end else if (result_ready) begin
          m_st = 0;
        end
        m_last = count_in;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // mode 0: toggle starting high; mode 1: held high
  task automatic run_wait(input int mode, output int lat);
    int i;
    i = 0;
    lat = 0;
    forever begin
      step();
      lat++;
      if (valid0 || lat >= 300) break;
      start = 1'b0;
      count_in = (mode == 0) ? ((i % 2) == 0) : 1'b1;
      i++;
    end
    if (!valid0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: result_valid never rose within %0d cycles", lat);
    end
  endtask

  task automatic do_run(input logic [7:0] w, input int mode, output int lat);
    window = w;
    start = 1'b1;
    count_in = 1'b0;
    run_wait(mode, lat);
  endtask

  initial begin
    int lat;
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; clear = 1'b0; count_in = 1'b0; start = 1'b0;
    window = 8'd0; result_ready = 1'b0;
    #1;
    check("reset_busy", 32'(busy0), 0);
    check("reset_result", 32'(result0), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // window 10, toggling: 5 edges, valid 11 cycles after start
    do_run(8'd10, 0, lat);
    check("w10_latency", 32'(lat), 11);
    check("w10_result", 32'(result0), 5);
    check("w10_valid", 32'(valid0), 1);
    result_ready = 1'b1; step(); result_ready = 1'b0;
    check("w10_taken", 32'(busy0), 0);
    check("w10_result_kept", 32'(result0), 5);

    // window 0 -> single sampled cycle with a rising edge
    step();
    do_run(8'd0, 1, lat);
    check("w0_latency", 32'(lat), 2);
    check("w0_result", 32'(result0), 1);
    result_ready = 1'b1; step(); result_ready = 1'b0;
    count_in = 1'b0; step();

    // window 40, 20 edges: 8-bit holds 20, 3-bit saturates at 7
    do_run(8'd40, 0, lat);
    check("w40_latency", 32'(lat), 41);
    check("w40_result8", 32'(result0), 20);
    check("w40_ovf8", 32'(ovf0), 0);
    check("w40_result3", 32'(result1), 7);
    check("w40_ovf3", 32'(ovf1), 1);
    result_ready = 1'b1; step(); result_ready = 1'b0;
    count_in = 1'b0; step();

    // asynchronous reset mid-run
    window = 8'd40; start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      count_in = ((i % 2) == 0);
      step();
    end
    check("mid_ovf3_set", 32'(ovf1), 1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy0), 0);
    check("rst_result8", 32'(result0), 0);
    check("rst_valid", 32'(valid0), 0);
    check("rst_result3", 32'(result1), 0);
    check("rst_ovf3", 32'(ovf1), 0);
    step(); step();
    rst_n = 1'b1; count_in = 1'b0;
    step();

    // HOLD stalled, then ready+start together, then start accepted
    do_run(8'd3, 0, lat);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", 32'(valid0), 1);
      check("hold_result", 32'(result0), 2);
    end
    result_ready = 1'b1; start = 1'b1; window = 8'd2;
    step();
    result_ready = 1'b0;
    check("ready_start_idle", 32'(busy0), 0);
    step();
    check("start_after_hold", 32'(busy0), 1);
    run_wait(0, lat);
    result_ready = 1'b1; step(); result_ready = 1'b0;

    // clear with start in IDLE, then clear mid-run
    clear = 1'b1; start = 1'b1; window = 8'd5;
    step();
    clear = 1'b0; start = 1'b0;
    check("clear_start_busy", 32'(busy0), 0);
    window = 8'd20; start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    clear = 1'b1; step(); clear = 1'b0;
    check("clear_run_busy", 32'(busy0), 0);
    check("clear_run_result", 32'(result0), 0);
    for (int i = 0; i < 25; i++) begin
      step();
      check("clear_no_valid", 32'(valid0), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
